hdmi_packet_island: RTL

Parametrised HDMI data-island packet scheduler and BCH encoder. It replaces the fixed two-packets-per-line generator with a buffered, generic packet path. Upstream producers push complete packets (24-bit header plus four 56-bit subpackets) into an internal FIFO. The block emits up to MAX_PACKETS per horizontal blanking interval as raw 4-bit TERC4 nibbles with BCH parity appended. It sits between the packet sources (audio sample, ACR and InfoFrame builders) and the TMDS/TERC4 channel encoders, which add preamble and guard bands around o_data.

---
 rtl/hdmi_packet_island.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/hdmi_packet_island.sv
// HDMI data-island scheduler: buffers whole packets, emits up to MAX_PACKETS per hblank with BCH parity.
// Outputs registered; first island clock START_OFFSET+1 clocks after the hsync leading edge.
module hdmi_packet_island #(
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_PACKETS  = 2,
    parameter int START_OFFSET = 0,
    parameter bit HSYNC_POL    = 1'b1
) (
    input  logic                          i_pixclk,
    input  logic                          i_reset,
    input  logic                          i_hSync,
    input  logic                          i_vSync,
    input  logic                          i_blank,
    input  logic                          i_enable,
    input  logic                          i_pkt_valid,
    output logic                          o_pkt_ready,
    input  logic [23:0]                   i_pkt_header,
    input  logic [223:0]                  i_pkt_sub,
    output logic [3:0]                    o_d0,
    output logic [3:0]                    o_d1,
    output logic [3:0]                    o_d2,
    output logic                          o_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [7:0]                    o_drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t          state, nstate;
    logic [23:0]     hdr_mem [FIFO_DEPTH];
    logic [223:0]    sub_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            full, push, pop;

    logic            hs_prev, hs_lead;
    logic [7:0]      dly;
    logic [4:0]      bit_cnt, emit_cnt, budget, budget_init;
    logic            emit, first_isl, abort;

    logic [23:0]     hdr_sr, src_hdr, hdr_n;
    logic [223:0]    sub_sr, src_sub, sub_n;
    logic [7:0]      hcode, src_hcode, hcode_n;
    logic [3:0][7:0] scode, src_scode, scode_n;
    logic            hbit;
    logic [3:0]      d1_n, d2_n;

    function automatic logic [7:0] bch_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'hC1 : 8'h00);
    endfunction

    assign full        = (o_fifo_level == LW'(FIFO_DEPTH));
    assign o_pkt_ready = !full && !i_reset;
    assign push        = i_pkt_valid && o_pkt_ready;
    assign hs_lead     = (hs_prev != HSYNC_POL) && (i_hSync == HSYNC_POL);

    always_comb begin
        if (int'(o_fifo_level) > MAX_PACKETS)
            budget_init = 5'(MAX_PACKETS);
        else
            budget_init = 5'(o_fifo_level);
    end

    always_comb begin
        nstate    = state;
        emit      = 1'b0;
        first_isl = 1'b0;
        abort     = 1'b0;
        emit_cnt  = bit_cnt;
        case (state)
            IDLE: if (hs_lead && i_blank) nstate = WAIT;
            WAIT: begin
                if (!i_blank) begin
                    nstate = IDLE;
                end else if (dly == 8'd0) begin
                    if (i_enable && o_fifo_level != '0) begin
                        nstate    = SEND;
                        emit      = 1'b1;
                        first_isl = 1'b1;
                        emit_cnt  = 5'd0;
                    end else begin
                        nstate = IDLE;
                    end
                end
            end
            SEND: begin
                if (!i_blank) begin
                    nstate = IDLE;
                    // only a partially sent packet counts as dropped
                    abort  = (bit_cnt != 5'd0);
                end else begin
                    emit = 1'b1;
                    if (bit_cnt == 5'd31 && budget <= 5'd1) nstate = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
        pop = emit && (emit_cnt == 5'd0);
    end

    // On the pop clock the FIFO head feeds the encoder directly so bit 0 leaves without delay.
    always_comb begin
        src_hdr   = pop ? hdr_mem[rd_ptr] : hdr_sr;
        src_sub   = pop ? sub_mem[rd_ptr] : sub_sr;
        src_hcode = pop ? 8'h00 : hcode;
        src_scode = pop ? '0 : scode;
        hdr_n     = src_hdr;
        sub_n     = src_sub;
        hcode_n   = src_hcode;
        scode_n   = src_scode;
        hbit      = 1'b0;
        d1_n      = 4'd0;
        d2_n      = 4'd0;
        if (emit_cnt < 5'd24) begin
            hbit    = src_hdr[0];
            hcode_n = bch_step(src_hcode, src_hdr[0]);
            hdr_n   = {1'b0, src_hdr[23:1]};
        end else begin
            hbit    = src_hcode[7];
            hcode_n = {src_hcode[6:0], 1'b0};
        end
        for (int k = 0; k < 4; k++) begin
            if (emit_cnt < 5'd28) begin
                d1_n[k]    = src_sub[56*k];
                d2_n[k]    = src_sub[56*k+1];
                scode_n[k] = bch_step(bch_step(src_scode[k], src_sub[56*k]), src_sub[56*k+1]);
            end else begin
                d1_n[k]    = src_scode[k][7];
                d2_n[k]    = src_scode[k][6];
                scode_n[k] = {src_scode[k][5:0], 2'b00};
            end
        end
        if (emit_cnt < 5'd28) sub_n = {2'b00, src_sub[223:2]};
    end

    always_ff @(posedge i_pixclk) begin
        if (push) begin
            hdr_mem[wr_ptr] <= i_pkt_header;
            sub_mem[wr_ptr] <= i_pkt_sub;
        end
    end

    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_fifo_level <= '0;
            hs_prev      <= 1'b0;
            dly          <= 8'd0;
            bit_cnt      <= 5'd0;
            budget       <= 5'd0;
            hdr_sr       <= '0;
            sub_sr       <= '0;
            hcode        <= '0;
            scode        <= '0;
            o_d0         <= 4'd0;
            o_d1         <= 4'd0;
            o_d2         <= 4'd0;
            o_data       <= 1'b0;
            o_drop_count <= 8'd0;
        end else begin
            state   <= nstate;
            hs_prev <= i_hSync;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            o_fifo_level <= o_fifo_level + LW'(push) - LW'(pop);

            if (state == IDLE && nstate == WAIT)
                dly <= 8'(START_OFFSET);
            else if (state == WAIT && dly != 8'd0)
                dly <= dly - 8'd1;

            bit_cnt <= (nstate == SEND) ? emit_cnt + 5'd1 : 5'd0;
            if (first_isl)
                budget <= budget_init;
            else if (emit && emit_cnt == 5'd31)
                budget <= budget - 5'd1;

            if (emit) begin
                hdr_sr <= hdr_n;
                sub_sr <= sub_n;
                hcode  <= hcode_n;
                scode  <= scode_n;
            end

            if (abort && o_drop_count != 8'hFF)
                o_drop_count <= o_drop_count + 8'd1;

            o_data <= emit;
            o_d0   <= emit ? {~first_isl, hbit, i_vSync, i_hSync} : {2'b00, i_vSync, i_hSync};
            o_d1   <= emit ? d1_n : 4'd0;
            o_d2   <= emit ? d2_n : 4'd0;
        end
    end
endmodule
